// File: rtl/sha256_arbiter_if.sv
// sha256_arbiter_if: arbiter bundle; requester blk_* ports, core_* command/status, dig_* digest output, busy; master = arbiter, slave = environment
interface sha256_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDW = 3
);
  logic [NUM_REQ-1:0] blk_valid, blk_first, blk_last, blk_mode, blk_ready;
  logic [NUM_REQ*512-1:0] blk_data;
  logic core_init, core_next, core_mode, core_ready;
  logic [511:0] core_block;
  logic [255:0] core_digest, dig_data;
  logic dig_valid, busy;
  logic [IDW-1:0] dig_id;
  modport master (
    input blk_valid, blk_first, blk_last, blk_mode, blk_data, core_ready, core_digest,
    output blk_ready, core_init, core_next, core_mode, core_block, dig_valid, dig_id, dig_data, busy
  );
  modport slave (
    output blk_valid, blk_first, blk_last, blk_mode, blk_data, core_ready, core_digest,
    input blk_ready, core_init, core_next, core_mode, core_block, dig_valid, dig_id, dig_data, busy
  );
endinterface

// File: rtl/sha256_arbiter.sv
// sha256_arbiter: shares one sha256_core among NUM_REQ block requesters, locked per message; ports clk, reset (sync, active-high), bus (master modport)
module sha256_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW = 3
) (
  input logic clk,
  input logic reset,
  sha256_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
  state_t state;
  logic [IDW-1:0] rr, owner, sel;
  logic locked, last_r, init_r, hit;
  logic [NUM_REQ-1:0] el;
  logic [2*NUM_REQ-1:0] el2;
  always_comb begin
    el = '0;
    for (int i = 0; i < NUM_REQ; i++)
      el[i] = bus.blk_valid[i] & (locked ? owner == IDW'(i) : bus.blk_first[i]);
    el2 = {el, el};
    hit = 1'b0;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (el2[int'(rr) + k]) begin
        hit = 1'b1;
        sel = IDW'((int'(rr) + k) % NUM_REQ);
      end
  end
  assign bus.busy = state != IDLE || locked;
  always_ff @(posedge clk) begin
    bus.blk_ready <= '0;
    bus.core_init <= 1'b0;
    bus.core_next <= 1'b0;
    bus.dig_valid <= 1'b0;
    if (reset) begin
      state <= IDLE;
      rr <= '0;
      owner <= '0;
      locked <= 1'b0;
      last_r <= 1'b0;
      init_r <= 1'b0;
      bus.core_mode <= 1'b0;
      bus.core_block <= '0;
      bus.dig_id <= '0;
      bus.dig_data <= '0;
    end else begin
      case (state)
        IDLE: if (bus.core_ready && hit) begin
          bus.blk_ready[sel] <= 1'b1;
          bus.core_block <= bus.blk_data[sel*512 +: 512];
          last_r <= bus.blk_last[sel];
          if (bus.blk_first[sel]) bus.core_mode <= bus.blk_mode[sel];
          init_r <= bus.blk_first[sel];
          owner <= sel;
          locked <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          bus.core_init <= init_r;
          bus.core_next <= !init_r;
          state <= WAIT_START;
        end
        WAIT_START: if (!bus.core_ready) state <= WAIT_DONE;
        WAIT_DONE: if (bus.core_ready) begin
          if (last_r) begin
            bus.dig_data <= bus.core_digest;
            bus.dig_valid <= 1'b1;
            bus.dig_id <= owner;
            locked <= 1'b0;
            rr <= owner == IDW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
          end
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_arbiter.sv
// tb_sha256_arbiter: directed tests of sha256_arbiter driving a behavioural SHA-256 core
module tb_sha256_arbiter;
  localparam int N = 2;
  localparam int LAT = 6;
  localparam logic [511:0] ABC = {24'h616263, 8'h80, 416'h0, 64'd24};
  localparam logic [447:0] TWO_MSG = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  localparam logic [511:0] B1 = {TWO_MSG, 8'h80, 56'h0};
  localparam logic [511:0] B2 = {448'h0, 64'd448};
  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [223:0] ABC224 = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
  localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic clk = 1'b0;
  logic reset = 1'b1;
  int pass_n = 0;
  int total = 0;
  always #5 clk = ~clk;
  sha256_arbiter_if #(.NUM_REQ(N), .IDW(3)) bus();
  sha256_arbiter #(.NUM_REQ(N), .IDW(3)) dut(.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, bb, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + bb, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction
  logic [255:0] h_st;
  int cnt;
  always @(posedge clk)
    if (reset) begin
      bus.core_ready <= 1'b0;
      bus.core_digest <= '0;
      h_st <= '0;
      cnt <= 3;
    end else if (bus.core_init || bus.core_next) begin
      h_st <= compress(bus.core_init ? (bus.core_mode ? IV256 : IV224) : h_st, bus.core_block);
      bus.core_ready <= 1'b0;
      cnt <= LAT;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        bus.core_ready <= 1'b1;
        bus.core_digest <= h_st;
      end
    end
  int cyc = 0;
  int multi = 0;
  int rise_cyc = 0;
  logic prev_rdy = 1'b0;
  int gnt_q[$];
  int gnt_cyc[$];
  bit cmd_q[$];
  int cmd_cyc[$];
  logic [255:0] dig_q[$];
  int dig_id_q[$];
  int dig_cyc[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if ($countones(bus.blk_ready) > 1) multi <= multi + 1;
    for (int i = 0; i < N; i++)
      if (bus.blk_ready[i]) begin
        gnt_q.push_back(i);
        gnt_cyc.push_back(cyc);
      end
    if (bus.core_init || bus.core_next) begin
      cmd_q.push_back(bus.core_init);
      cmd_cyc.push_back(cyc);
    end
    if (bus.dig_valid) begin
      dig_q.push_back(bus.dig_data);
      dig_id_q.push_back(int'(bus.dig_id));
      dig_cyc.push_back(cyc);
    end
    if (bus.core_ready && !prev_rdy) rise_cyc <= cyc;
    prev_rdy <= bus.core_ready;
  end
  task automatic req(input int r, input bit f, input bit l, input bit m, input logic [511:0] d, output bit ok);
    bus.blk_valid[r] = 1'b1;
    bus.blk_first[r] = f;
    bus.blk_last[r] = l;
    bus.blk_mode[r] = m;
    bus.blk_data[r*512 +: 512] = d;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.blk_ready[r];
    end
    bus.blk_valid[r] = 1'b0;
  endtask
  task automatic wait_dig(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = dig_q.size() >= n;
    end
  endtask
  task automatic test_reset();
    bit bad = 1'b0;
    bus.blk_valid = '0;
    bus.blk_first = '0;
    bus.blk_last = '0;
    bus.blk_mode = '0;
    bus.blk_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({bus.blk_ready, bus.core_init, bus.core_next, bus.dig_valid, bus.busy} !== '0)
      $display("FAIL reset_ctl got %b exp 0", {bus.blk_ready, bus.core_init, bus.core_next, bus.dig_valid, bus.busy}); else pass_n++;
    total++; if (bus.dig_data !== '0 || bus.dig_id !== '0) $display("FAIL reset_dig got %h/%0d exp 0/0", bus.dig_data, bus.dig_id); else pass_n++;
    total++; if (bus.core_block !== '0 || bus.core_mode !== 1'b0) $display("FAIL reset_core got %h/%b exp 0/0", bus.core_block, bus.core_mode); else pass_n++;
    reset = 1'b0;
    bus.blk_valid[0] = 1'b1;
    bus.blk_first[0] = 1'b1;
    bus.blk_last[0] = 1'b1;
    bus.blk_data[511:0] = ABC;
    for (int i = 0; i < 20 && !bus.core_ready; i++) begin
      @(negedge clk);
      if (bus.blk_ready !== '0) bad = 1'b1;
    end
    bus.blk_valid[0] = 1'b0;
    total++; if (bad !== 1'b0) $display("FAIL no_grant_core_busy got grant exp none"); else pass_n++;
  endtask
  task automatic test_abc(input bit m);
    int g0 = gnt_q.size();
    int c0 = cmd_q.size();
    int d0 = dig_q.size();
    bit ok, ok2;
    req(0, 1'b1, 1'b1, m, ABC, ok);
    wait_dig(d0 + 1, ok2);
    total++; if ({ok, ok2} !== 2'b11) $display("FAIL abc%0d_done got %b exp 11", m, {ok, ok2}); else pass_n++;
    total++; if (bus.busy !== 1'b0) $display("FAIL abc%0d_busy got %b exp 0", m, bus.busy); else pass_n++;
    repeat (4) @(negedge clk);
    total++; if (cmd_q.size() != c0 + 1 || cmd_q[c0] !== 1'b1) $display("FAIL abc%0d_cmd got %0d cmds exp 1 init", m, cmd_q.size() - c0); else pass_n++;
    total++; if (cmd_cyc[c0] != gnt_cyc[g0] + 1) $display("FAIL abc%0d_cmd_lat got %0d exp %0d", m, cmd_cyc[c0], gnt_cyc[g0] + 1); else pass_n++;
    total++; if (dig_cyc[d0] != rise_cyc + 1) $display("FAIL abc%0d_dig_lat got %0d exp %0d", m, dig_cyc[d0], rise_cyc + 1); else pass_n++;
    total++; if (dig_q.size() != d0 + 1 || dig_id_q[d0] != 0) $display("FAIL abc%0d_dig_once got %0d pulses id %0d exp 1 id 0", m, dig_q.size() - d0, dig_id_q[d0]); else pass_n++;
    total++; if (bus.core_mode !== m) $display("FAIL abc%0d_mode got %b exp %b", m, bus.core_mode, m); else pass_n++;
    if (m) begin
      total++; if (bus.dig_data !== ABC256) $display("FAIL abc256_data got %h exp %h", bus.dig_data, ABC256); else pass_n++;
    end else begin
      total++; if (bus.dig_data[255:32] !== ABC224) $display("FAIL abc224_data got %h exp %h", bus.dig_data[255:32], ABC224); else pass_n++;
    end
  endtask
  task automatic test_two_block();
    int g0 = gnt_q.size();
    int c0 = cmd_q.size();
    int d0 = dig_q.size();
    bit oka, okb, okc, okd;
    fork
      begin
        req(0, 1'b1, 1'b0, 1'b1, B1, oka);
        req(0, 1'b0, 1'b1, 1'b1, B2, okb);
      end
      begin
        for (int i = 0; i < 300 && !bus.blk_ready[0]; i++) @(negedge clk);
        req(1, 1'b1, 1'b1, 1'b1, ABC, okc);
      end
    join
    wait_dig(d0 + 2, okd);
    total++; if ({oka, okb, okc, okd} !== 4'hf) $display("FAIL two_done got %b exp 1111", {oka, okb, okc, okd}); else pass_n++;
    total++; if (gnt_q[g0] != 0 || gnt_q[g0+1] != 0 || gnt_q[g0+2] != 1)
      $display("FAIL two_gnt got %0d%0d%0d exp 001", gnt_q[g0], gnt_q[g0+1], gnt_q[g0+2]); else pass_n++;
    total++; if ({cmd_q[c0], cmd_q[c0+1], cmd_q[c0+2]} !== 3'b101) $display("FAIL two_cmd got %b exp 101 (init,next,init)", {cmd_q[c0], cmd_q[c0+1], cmd_q[c0+2]}); else pass_n++;
    total++; if (dig_q[d0] !== TWO256 || dig_id_q[d0] != 0) $display("FAIL two_r0_dig got %h id %0d exp %h id 0", dig_q[d0], dig_id_q[d0], TWO256); else pass_n++;
    total++; if (dig_q[d0+1] !== ABC256 || dig_id_q[d0+1] != 1) $display("FAIL two_r1_dig got %h id %0d exp %h id 1", dig_q[d0+1], dig_id_q[d0+1], ABC256); else pass_n++;
    total++; if (gnt_cyc[g0+2] <= dig_cyc[d0]) $display("FAIL two_r1_wait got grant cyc %0d exp after %0d", gnt_cyc[g0+2], dig_cyc[d0]); else pass_n++;
  endtask
  task automatic test_back_to_back();
    int g0 = gnt_q.size();
    int d0 = dig_q.size();
    bit oka = 1'b1, okb = 1'b1, t0, t1, okd, seq_ok = 1'b1, dig_ok = 1'b1;
    fork
      repeat (3) begin req(0, 1'b1, 1'b1, 1'b1, ABC, t0); oka &= t0; end
      repeat (3) begin req(1, 1'b1, 1'b1, 1'b0, ABC, t1); okb &= t1; end
    join
    wait_dig(d0 + 6, okd);
    for (int i = 0; i < 6; i++) begin
      if (gnt_q.size() <= g0 + i || gnt_q[g0+i] != i % 2) seq_ok = 1'b0;
      if (dig_id_q[d0+i] != i % 2) dig_ok = 1'b0;
      if (i % 2 == 0 && dig_q[d0+i] !== ABC256) dig_ok = 1'b0;
      if (i % 2 == 1 && dig_q[d0+i][255:32] !== ABC224) dig_ok = 1'b0;
    end
    total++; if ({oka, okb, okd} !== 3'b111) $display("FAIL b2b_done got %b exp 111", {oka, okb, okd}); else pass_n++;
    total++; if (seq_ok !== 1'b1) $display("FAIL b2b_order got not alternating exp 0,1,0,1,0,1"); else pass_n++;
    total++; if (dig_ok !== 1'b1) $display("FAIL b2b_digests got wrong id/data exp alternating r0 sha256, r1 sha224"); else pass_n++;
    total++; if (multi != 0) $display("FAIL one_hot_ready got %0d multi-grant cycles exp 0", multi); else pass_n++;
  endtask
  task automatic test_abort();
    int d0 = dig_q.size();
    int d1, g1;
    bit oka, okb, okc, okd, oke, okf;
    req(0, 1'b1, 1'b1, 1'b1, ABC, oka);
    wait_dig(d0 + 1, okb);
    req(0, 1'b1, 1'b1, 1'b1, ABC, okc);
    for (int i = 0; i < 20 && bus.core_ready; i++) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({bus.blk_ready, bus.core_init, bus.core_next, bus.dig_valid, bus.busy} !== '0)
      $display("FAIL abort_ctl got %b exp 0", {bus.blk_ready, bus.core_init, bus.core_next, bus.dig_valid, bus.busy}); else pass_n++;
    total++; if (bus.core_block !== '0 || bus.dig_data !== '0) $display("FAIL abort_data got %h/%h exp 0/0", bus.core_block, bus.dig_data); else pass_n++;
    d1 = dig_q.size();
    repeat (15) @(negedge clk);
    total++; if (dig_q.size() != d1) $display("FAIL abort_no_dig got %0d digests exp 0", dig_q.size() - d1); else pass_n++;
    g1 = gnt_q.size();
    fork
      req(0, 1'b1, 1'b1, 1'b1, ABC, okd);
      req(1, 1'b1, 1'b1, 1'b0, ABC, oke);
    join
    wait_dig(d1 + 2, okf);
    total++; if ({oka, okb, okc, okd, oke, okf} !== 6'h3f) $display("FAIL abort_done got %b exp 111111", {oka, okb, okc, okd, oke, okf}); else pass_n++;
    total++; if (gnt_q[g1] != 0 || gnt_q[g1+1] != 1) $display("FAIL abort_rr got %0d%0d exp 01", gnt_q[g1], gnt_q[g1+1]); else pass_n++;
    total++; if (dig_q[d1] !== ABC256 || dig_id_q[d1] != 0) $display("FAIL abort_new_dig got %h id %0d exp %h id 0", dig_q[d1], dig_id_q[d1], ABC256); else pass_n++;
  endtask
  task automatic test_protocol_error();
    int g0 = gnt_q.size();
    int d0 = dig_q.size();
    bit oka, okb;
    bus.blk_valid[0] = 1'b1;
    bus.blk_first[0] = 1'b0;
    bus.blk_last[0] = 1'b1;
    bus.blk_data[511:0] = ABC;
    req(1, 1'b1, 1'b1, 1'b1, ABC, oka);
    wait_dig(d0 + 1, okb);
    repeat (20) @(negedge clk);
    total++; if ({oka, okb} !== 2'b11) $display("FAIL proterr_r1_done got %b exp 11", {oka, okb}); else pass_n++;
    total++; if (gnt_q.size() != g0 + 1 || gnt_q[g0] != 1) $display("FAIL proterr_gnt got %0d grants first %0d exp 1 grant to 1", gnt_q.size() - g0, gnt_q[g0]); else pass_n++;
    total++; if (dig_q[d0] !== ABC256 || dig_id_q[d0] != 1) $display("FAIL proterr_dig got %h id %0d exp %h id 1", dig_q[d0], dig_id_q[d0], ABC256); else pass_n++;
    total++; if (bus.busy !== 1'b0) $display("FAIL proterr_busy got %b exp 0", bus.busy); else pass_n++;
    bus.blk_valid[0] = 1'b0;
  endtask
  initial begin
    test_reset();
    test_abc(1'b1);
    test_abc(1'b0);
    test_two_block();
    test_back_to_back();
    test_abort();
    test_protocol_error();
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule

// File: doc/sha256_arbiter.md
# sha256_arbiter

Shares one `sha256_core` between `NUM_REQ` requesters that each submit a message as a stream of pre-padded 512-bit blocks. The block issues the core's `init` and `next` commands and sequences each block through the core. It holds the core for one requester from the first block of a message to the last, because the core keeps the chaining state. It returns one digest per completed message and sits between the requester ports and a single `sha256_core` instance.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters (2..8).
- `IDW`, default 3: width of the requester index.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `blk_valid` in NUM_REQ: requester i has a block available.
- `blk_first` in NUM_REQ: the block is the first block of a message.
- `blk_last` in NUM_REQ: the block is the last block of a message (both first and last may be set).
- `blk_mode` in NUM_REQ: 1 = SHA-256, 0 = SHA-224; sampled on the first block only.
- `blk_data` in NUM_REQ*512: block of requester i at `[i*512 +: 512]`.
- `blk_ready` out NUM_REQ: one-cycle accept pulse for requester i.
- `core_init` out 1: init command to the core.
- `core_next` out 1: next command to the core.
- `core_mode` out 1: mode to the core.
- `core_block` out 512: block to the core.
- `core_ready` in 1: core ready.
- `core_digest` in 256: core digest.
- `dig_valid` out 1: one-cycle pulse, message digest available.
- `dig_id` out IDW: requester that owns the digest.
- `dig_data` out 256: digest; valid while `dig_valid` = 1.
- `busy` out 1: high when the FSM is not in IDLE or a message is locked.

## Operation

FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.

**IDLE**
- Accepts a block only when `core_ready` = 1.
- Unlocked: the eligible set is requesters with `blk_valid` = 1 and `blk_first` = 1. A requester with `blk_valid` = 1 and `blk_first` = 0 is never granted while unlocked; it is a protocol error and stays pending.
- Unlocked selection: round-robin search starting at pointer `rr`.
- Locked: only the owner is eligible. Other requesters wait.
- On a grant:
  - pulse `blk_ready[i]`;
  - register `blk_data[i]` into `core_block`;
  - register `blk_last[i]`;
  - register `blk_mode[i]` into `core_mode` if first;
  - record the command type: init if `blk_first` = 1, else next;
  - set owner = i and lock;
  - go to ISSUE.
- Owner sends `blk_first` = 1 while locked: the message restarts with init. The owner keeps the lock.

**ISSUE**
- Drive `core_init` or `core_next` high for exactly one cycle, then go to WAIT_START.

**WAIT_START**
- Wait for `core_ready` = 0, then go to WAIT_DONE.

**WAIT_DONE**
- Wait for `core_ready` = 1.
- If the registered last = 1:
  - register `core_digest` into `dig_data`;
  - pulse `dig_valid` with `dig_id` = owner;
  - unlock;
  - set `rr` = (owner+1) mod NUM_REQ.
- Go to IDLE.

Data rules:
- `core_block` and `core_mode` are held stable from the grant until the next grant.
- For SHA-224, `dig_data` carries the full 256-bit core output; the consumer uses `[255:32]`.
- `dig_data` holds its value until the next digest.

## Timing

- Reset values: all outputs 0, state IDLE, `rr` = 0, unlocked, owner = 0.
- Grant → command: `blk_ready` pulses in cycle T; `core_init`/`core_next` pulses in T+1.
- Core done → digest: `core_ready` rises in cycle D (WAIT_DONE); `dig_valid` = 1 in D+1. The FSM is in IDLE at D+1.
- The next grant can happen at D+1 (same cycle as `dig_valid`).
- Block throughput: 1 cycle to grant, plus 1 cycle to issue, plus the core latency, plus 1 cycle back to IDLE.
- Simultaneous `blk_valid` from several requesters: exactly one `blk_ready` bit is ever high per cycle.
- Requesters must hold `blk_valid`, `blk_data`, `blk_first`, `blk_last` and `blk_mode` stable until `blk_ready`.
- `dig_valid` has no backpressure.
- Reset asserted mid-message: next cycle all outputs are 0, the FSM is in IDLE and the lock is released. No digest is produced for the aborted message. The core is reset by its own reset.
- `core_ready` = 0 while in IDLE (for example, the core is still resetting): no grant is made.

## Test plan

1. Reset, then requester 0 sends "abc" as one padded block (first = last = 1, mode = 1) → one `core_init` pulse. `dig_valid` pulses once with `dig_id` = 0 and `dig_data` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
2. Same block with mode = 0 → `dig_data[255:32]` = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7.
3. Requester 0 sends the two-block "abcdbcdecdef…nopq" message. Requester 1 asserts a single-block request after the first grant → order is init(r0), next(r0), init(r1).
   - Digest r0 = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
   - `blk_ready[1]` stays 0 until r0's `dig_valid`.
4. Both requesters hold single-block requests continuously for 6 messages → grants alternate 0,1,0,1,0,1. No cycle has two `blk_ready` bits set.
5. Reset asserted during r0's WAIT_DONE, then released and "abc" resent → no `dig_valid` for the aborted message. `rr` = 0. The new digest is correct.
6. Requester 0 sends a block with `blk_first` = 0 while unlocked → never granted. Requester 1's valid first-block request is still served normally.
